// File: rtl/button_conditioner_pkg.sv
// Shared definitions for the push-button conditioner: debounce FSM encodings,
// default timing parameters and the per-channel output bundle.
package button_conditioner_pkg;

  localparam int DEBOUNCE_CYCLES_DEF = 50000;
  localparam int CNT_WIDTH_DEF       = 16;

  localparam logic [1:0] BTN_RELEASED        = 2'd0;
  localparam logic [1:0] BTN_CONFIRM_PRESS   = 2'd1;
  localparam logic [1:0] BTN_PRESSED         = 2'd2;
  localparam logic [1:0] BTN_CONFIRM_RELEASE = 2'd3;

  typedef struct packed {
    logic level;
    logic press;
    logic release_p;
  } btn_out_t;

endpackage

// File: rtl/button_conditioner_channel.sv
// One button channel: 2-flop synchronizer, debounce FSM with stability counter,
// and registered level / press / release outputs.
module button_debounce_channel
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_WIDTH       = CNT_WIDTH_DEF
) (
  input  logic     clock,
  input  logic     reset,
  input  logic     btn_i,
  output btn_out_t out_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_DONE = CNT_WIDTH'(DEBOUNCE_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  logic [1:0]           sync_q;
  logic [1:0]           state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 level_q, level_d;
  logic                 press_q, release_q;
  logic                 synced;

  assign synced = sync_q[1];

  // Counter is cleared on every abort and accept, so equality is enough.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      BTN_RELEASED: begin
        if (synced) begin
          state_d = BTN_CONFIRM_PRESS;
          cnt_d   = CNT_ONE;
        end
      end
      BTN_CONFIRM_PRESS: begin
        if (!synced) begin
          state_d = BTN_RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_DONE) begin
          state_d = BTN_PRESSED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      BTN_PRESSED: begin
        if (!synced) begin
          state_d = BTN_CONFIRM_RELEASE;
          cnt_d   = CNT_ONE;
        end
      end
      BTN_CONFIRM_RELEASE: begin
        if (synced) begin
          state_d = BTN_PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_DONE) begin
          state_d = BTN_RELEASED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = BTN_RELEASED;
        cnt_d   = '0;
      end
    endcase
  end

  assign level_d = (state_d == BTN_PRESSED) || (state_d == BTN_CONFIRM_RELEASE);

  // Edge pulses are computed from the next level so they line up with level_q.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q    <= '0;
      state_q   <= BTN_RELEASED;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], btn_i};
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= level_d & ~level_q;
      release_q <= ~level_d & level_q;
    end
  end

  assign out_o.level     = level_q;
  assign out_o.press     = press_q;
  assign out_o.release_p = release_q;

endmodule

// File: rtl/button_conditioner.sv
// Conditions raw board push-buttons into debounced levels and single-cycle
// press/release pulses in the processor clock domain.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int NUM_BUTTONS     = 4,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_WIDTH       = CNT_WIDTH_DEF,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_BUTTONS-1:0] btn_raw,
  output logic [NUM_BUTTONS-1:0] btn_level,
  output logic [NUM_BUTTONS-1:0] btn_press,
  output logic [NUM_BUTTONS-1:0] btn_release
);

  logic [NUM_BUTTONS-1:0] btn_norm;
  btn_out_t               ch_out [NUM_BUTTONS];

  // After normalization, 1 always means pressed.
  assign btn_norm = ACTIVE_LOW ? ~btn_raw : btn_raw;

  for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_ch
    button_debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_WIDTH       (CNT_WIDTH)
    ) u_ch (
      .clock (clock),
      .reset (reset),
      .btn_i (btn_norm[g]),
      .out_o (ch_out[g])
    );

    assign btn_level[g]   = ch_out[g].level;
    assign btn_press[g]   = ch_out[g].press;
    assign btn_release[g] = ch_out[g].release_p;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner with DEBOUNCE_CYCLES=4, active-low pins.
module tb_button_conditioner;

  localparam int NB  = 4;
  localparam int DB  = 4;
  localparam int LAT = DB + 3;

  logic          clock = 1'b0;
  logic          reset;
  logic [NB-1:0] btn_raw;
  logic [NB-1:0] btn_level, btn_press, btn_release;

  always #5 clock = ~clock;

  button_conditioner #(
    .NUM_BUTTONS     (NB),
    .DEBOUNCE_CYCLES (DB),
    .CNT_WIDTH       (16),
    .ACTIVE_LOW      (1'b1)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .btn_raw     (btn_raw),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release)
  );

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int            c;
    logic [NB-1:0] p;
    logic [NB-1:0] r;
  } ev_t;

  ev_t sbq[$];
  int  n_chk = 0;
  int  n_err = 0;
  bit  mon_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Every pulse must match the oldest queued expectation, cycle included.
  always @(negedge clock) begin
    ev_t e;
    if (mon_en && ((btn_press | btn_release) != '0)) begin
      if (sbq.size() == 0) begin
        chk("unexpected_pulse", {24'd0, btn_press, btn_release}, 32'd0);
      end else begin
        e = sbq.pop_front();
        chk("pulse_cycle", cyc, e.c);
        chk("press_mask", {28'd0, btn_press}, {28'd0, e.p});
        chk("release_mask", {28'd0, btn_release}, {28'd0, e.r});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic expect_ev(input int c, input logic [NB-1:0] p, input logic [NB-1:0] r);
    ev_t e;
    e.c = c;
    e.p = p;
    e.r = r;
    sbq.push_back(e);
  endtask

  task automatic level_at(input int c, input logic [NB-1:0] exp, input string tag);
    while (cyc < c) begin
      @(posedge clock);
      #1;
    end
    @(negedge clock);
    chk(tag, {28'd0, btn_level}, {28'd0, exp});
  endtask

  int t, r;

  initial begin
    reset   = 1'b1;
    btn_raw = '1;
    tick(1);
    mon_en = 1'b1;
    tick(2);
    chk("rst_level", {28'd0, btn_level}, 32'd0);
    chk("rst_press", {28'd0, btn_press}, 32'd0);
    chk("rst_release", {28'd0, btn_release}, 32'd0);
    reset = 1'b0;
    tick(20);
    chk("idle_level", {28'd0, btn_level}, 32'd0);

    // clean press / release on channel 0
    t = cyc; btn_raw[0] = 1'b0; expect_ev(t + LAT, 4'b0001, 4'b0000);
    level_at(t + LAT - 1, 4'b0000, "press0_early");
    level_at(t + LAT, 4'b0001, "press0_level");
    tick(23);
    t = cyc; btn_raw[0] = 1'b1; expect_ev(t + LAT, 4'b0000, 4'b0001);
    level_at(t + LAT - 1, 4'b0001, "release0_early");
    level_at(t + LAT, 4'b0000, "release0_level");
    tick(10);

    // bounce on channel 1, then settle low
    for (int i = 0; i < 5; i++) begin
      btn_raw[1] = 1'b0; tick(2);
      btn_raw[1] = 1'b1; tick(2);
    end
    chk("bounce_idle", {28'd0, btn_level}, 32'd0);
    t = cyc; btn_raw[1] = 1'b0; expect_ev(t + LAT, 4'b0010, 4'b0000);
    level_at(t + LAT, 4'b0010, "bounce_level");
    tick(5);
    t = cyc; btn_raw[1] = 1'b1; expect_ev(t + LAT, 4'b0000, 4'b0010);
    tick(12);

    // glitches of 3 and DB cycles are rejected
    btn_raw[2] = 1'b0; tick(3); btn_raw[2] = 1'b1; tick(15);
    chk("glitch3_level", {28'd0, btn_level}, 32'd0);
    btn_raw[2] = 1'b0; tick(DB); btn_raw[2] = 1'b1; tick(15);
    chk("glitch4_level", {28'd0, btn_level}, 32'd0);

    // DB+1 low cycles is the shortest accepted press; release follows DB+1 later
    t = cyc; btn_raw[2] = 1'b0;
    expect_ev(t + LAT, 4'b0100, 4'b0000);
    tick(DB + 1);
    btn_raw[2] = 1'b1;
    expect_ev(t + DB + 1 + LAT, 4'b0000, 4'b0100);
    tick(20);

    // simultaneous press and release on all channels
    t = cyc; btn_raw = 4'b0000; expect_ev(t + LAT, 4'b1111, 4'b0000);
    level_at(t + LAT, 4'b1111, "all_level");
    tick(5);
    t = cyc; btn_raw = 4'b1111; expect_ev(t + LAT, 4'b0000, 4'b1111);
    level_at(t + LAT, 4'b0000, "all_release_level");
    tick(5);

    // reset mid-confirm on channel 3
    t = cyc; btn_raw[3] = 1'b0;
    tick(5);
    reset = 1'b1;
    tick(3);
    chk("midrst_level", {28'd0, btn_level}, 32'd0);
    chk("midrst_press", {28'd0, btn_press}, 32'd0);
    reset = 1'b0;
    r = cyc; expect_ev(r + LAT, 4'b1000, 4'b0000);
    level_at(r + LAT, 4'b1000, "midrst_level_after");
    tick(3);
    t = cyc; btn_raw[3] = 1'b1; expect_ev(t + LAT, 4'b0000, 4'b1000);
    tick(12);

    // reset while pressed clears outputs; held button re-debounces afterwards
    t = cyc; btn_raw[0] = 1'b0; expect_ev(t + LAT, 4'b0001, 4'b0000);
    level_at(t + LAT, 4'b0001, "held_level");
    tick(2);
    reset = 1'b1;
    tick(1);
    chk("force_rst_level", {28'd0, btn_level}, 32'd0);
    tick(1);
    reset = 1'b0;
    r = cyc; expect_ev(r + LAT, 4'b0001, 4'b0000);
    level_at(r + LAT, 4'b0001, "held_after_rst_level");
    tick(2);
    t = cyc; btn_raw[0] = 1'b1; expect_ev(t + LAT, 4'b0000, 4'b0001);
    tick(15);

    chk("sb_pending", sbq.size(), 32'd0);
    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
